// File: rtl/id_exe_interlock_if.sv
// id_exe_interlock_if: ID/EXE boundary bundle.
//   master : ID-side driver (decoded ID fields, flush, WB write port);
//            sees wpcir and the registered EXE fields.
//   slave  : the interlock block; drives wpcir and the EXE fields.
// Parameters: DW datapath width, RW register-number width.
interface id_exe_interlock_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
);
  // ID-stage decoded instruction
  logic          id_wreg;
  logic          id_m2reg;
  logic          id_wmem;
  logic [2:0]    id_aluc;
  logic          id_aluimm;
  logic          id_shift;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_d;
  logic          id_usert;
  logic [DW-1:0] id_qa;
  logic [DW-1:0] id_qb;
  logic [DW-1:0] id_imm;

  // Squash and WB register-file write port
  logic          flush;
  logic          wb_wreg;
  logic [RW-1:0] wb_d;
  logic [DW-1:0] wdi;

  // Interlock result and EXE pipeline register
  logic          wpcir;
  logic          exe_wreg;
  logic          exe_m2reg;
  logic          exe_wmem;
  logic [2:0]    ealuc;
  logic          ealuimm;
  logic          eshift;
  logic [DW-1:0] ea;
  logic [DW-1:0] eb;
  logic [DW-1:0] eimm;
  logic [RW-1:0] exe_rs;
  logic [RW-1:0] exe_rt;
  logic [RW-1:0] exe_d;

  modport master (
    output id_wreg, id_m2reg, id_wmem, id_aluc, id_aluimm, id_shift,
           id_rs, id_rt, id_d, id_usert, id_qa, id_qb, id_imm,
           flush, wb_wreg, wb_d, wdi,
    input  wpcir, exe_wreg, exe_m2reg, exe_wmem, ealuc, ealuimm, eshift,
           ea, eb, eimm, exe_rs, exe_rt, exe_d
  );

  modport slave (
    input  id_wreg, id_m2reg, id_wmem, id_aluc, id_aluimm, id_shift,
           id_rs, id_rt, id_d, id_usert, id_qa, id_qb, id_imm,
           flush, wb_wreg, wb_d, wdi,
    output wpcir, exe_wreg, exe_m2reg, exe_wmem, ealuc, ealuimm, eshift,
           ea, eb, eimm, exe_rs, exe_rt, exe_d
  );
endinterface

// File: rtl/id_exe_interlock.sv
// id_exe_interlock: ID->EXE pipeline register with load-use interlock.
//   clk       : clock, all state updates on posedge
//   clrn      : asynchronous active-low reset (EXE register -> NOP bubble)
//   bus       : id_exe_interlock_if.slave
//               in : id_* decoded fields, flush, wb_wreg/wb_d/wdi
//               out: wpcir (combinational PC/IF-ID write enable),
//                    registered exe_*/ealuc/ealuimm/eshift/ea/eb/eimm
//   stall_cnt : saturating count of load-use stalls, present only when
//               ID_EXE_STALL_CNT_EN is defined
// A load in EXE whose destination is read by the ID instruction holds PC
// and IF/ID for one cycle and drops a bubble into EXE; the re-presented
// instruction then gets its operand via EXE forwarding from MEM/WB.
module id_exe_interlock #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic              clk,
  input  logic              clrn,
  id_exe_interlock_if.slave bus
`ifdef ID_EXE_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  // EXE pipeline register contents
  typedef struct packed {
    logic          wreg;
    logic          m2reg;
    logic          wmem;
    logic [2:0]    aluc;
    logic          aluimm;
    logic          shift;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] d;
  } exe_reg_t;

  exe_reg_t exe_q;
  exe_reg_t exe_nxt;
  logic     lu;
  logic     hit_rs;
  logic     hit_rt;
  logic     byp_a;
  logic     byp_b;

  // Load-use detection against the instruction currently in EXE.
  // rs is always a source; rt only when the instruction reads it; r0 never stalls.
  always_comb begin : hazard
    hit_rs = (exe_q.d == bus.id_rs);
    hit_rt = bus.id_usert && (exe_q.d == bus.id_rt);
    lu     = exe_q.wreg && exe_q.m2reg && (exe_q.d != '0) && (hit_rs || hit_rt);
  end

  // A flush redirects the PC even when a stall would otherwise hold it.
  assign bus.wpcir = ~lu | bus.flush;

  // Same-cycle WB write bypassed into the operands about to be captured.
  always_comb begin : wb_bypass
    byp_a = bus.wb_wreg && (bus.wb_d != '0) && (bus.wb_d == bus.id_rs);
    byp_b = bus.wb_wreg && (bus.wb_d != '0) && (bus.wb_d == bus.id_rt);
  end

  // Next EXE contents: all-zero bubble on flush or stall, else the ID fields.
  always_comb begin : next_exe
    exe_nxt = '0;
    if (!bus.flush && !lu) begin
      exe_nxt.wreg   = bus.id_wreg;
      exe_nxt.m2reg  = bus.id_m2reg;
      exe_nxt.wmem   = bus.id_wmem;
      exe_nxt.aluc   = bus.id_aluc;
      exe_nxt.aluimm = bus.id_aluimm;
      exe_nxt.shift  = bus.id_shift;
      exe_nxt.a      = byp_a ? bus.wdi : bus.id_qa;
      exe_nxt.b      = byp_b ? bus.wdi : bus.id_qb;
      exe_nxt.imm    = bus.id_imm;
      exe_nxt.rs     = bus.id_rs;
      exe_nxt.rt     = bus.id_rt;
      exe_nxt.d      = bus.id_d;
    end
  end

  // EXE pipeline register
  always_ff @(posedge clk or negedge clrn) begin : exe_reg
    if (!clrn) begin
      exe_q <= '0;
    end else begin
      exe_q <= exe_nxt;
    end
  end

  assign bus.exe_wreg  = exe_q.wreg;
  assign bus.exe_m2reg = exe_q.m2reg;
  assign bus.exe_wmem  = exe_q.wmem;
  assign bus.ealuc     = exe_q.aluc;
  assign bus.ealuimm   = exe_q.aluimm;
  assign bus.eshift    = exe_q.shift;
  assign bus.ea        = exe_q.a;
  assign bus.eb        = exe_q.b;
  assign bus.eimm      = exe_q.imm;
  assign bus.exe_rs    = exe_q.rs;
  assign bus.exe_rt    = exe_q.rt;
  assign bus.exe_d     = exe_q.d;

`ifdef ID_EXE_STALL_CNT_EN
  localparam int unsigned CW = 32;

  logic [CW-1:0] cnt_q;

  // Counts stalls that actually hold the pipe; flush-masked ones are excluded.
  always_ff @(posedge clk or negedge clrn) begin : stall_counter
    if (!clrn) begin
      cnt_q <= '0;
    end else if (lu && !bus.flush && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_id_exe_interlock.sv
// tb_id_exe_interlock: directed scoreboard bench for id_exe_interlock.
// Stimulus is applied on negedge and pushes the hand-computed wpcir and
// next EXE contents; two monitors pop and compare (wpcir before the edge,
// EXE register after it).
module tb_id_exe_interlock;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic clk  = 1'b0;
  logic clrn = 1'b0;

  always #5 clk = ~clk;

  id_exe_interlock_if #(.DW(DW), .RW(RW)) bus ();

`ifdef ID_EXE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  id_exe_interlock #(.DW(DW), .RW(RW)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .bus       (bus)
`ifdef ID_EXE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct packed {
    logic          clrn;
    logic          flush;
    logic          wreg;
    logic          m2reg;
    logic          wmem;
    logic [2:0]    aluc;
    logic          aluimm;
    logic          shift;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] d;
    logic          usert;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
    logic [DW-1:0] imm;
    logic          wb_wreg;
    logic [RW-1:0] wb_d;
    logic [DW-1:0] wdi;
    logic          exp_wpcir;
    logic          exp_bub;
    logic [DW-1:0] exp_ea;
    logic [DW-1:0] exp_eb;
  } vec_t;

  typedef struct packed {
    logic          wreg;
    logic          m2reg;
    logic          wmem;
    logic [2:0]    aluc;
    logic          aluimm;
    logic          shift;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] d;
  } exe_t;

  typedef struct {
    int   row;
    logic wpcir;
    exe_t e;
  } exp_t;

  exp_t wp_q[$];
  exp_t ex_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   row_id   = 0;

  // Instruction template; expectations default to "no stall, operands as read".
  function automatic vec_t instr(input logic wreg, input logic m2reg,
                                 input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                                 input logic [RW-1:0] d, input logic usert,
                                 input logic [DW-1:0] qa, input logic [DW-1:0] qb);
    vec_t v = '0;
    v.clrn      = 1'b1;
    v.wreg      = wreg;
    v.m2reg     = m2reg;
    v.aluc      = 3'(d);
    v.aluimm    = m2reg;
    v.rs        = rs;
    v.rt        = rt;
    v.d         = d;
    v.usert     = usert;
    v.qa        = qa;
    v.qb        = qb;
    v.imm       = DW'(32'h0000_1000) + DW'(d);
    v.exp_wpcir = 1'b1;
    v.exp_ea    = qa;
    v.exp_eb    = qb;
    return v;
  endfunction

  // Packs the row's hand-entered expectation into EXE register form.
  function automatic exe_t exp_of(input vec_t v);
    exe_t e = '0;
    if (!v.exp_bub) begin
      e.wreg   = v.wreg;
      e.m2reg  = v.m2reg;
      e.wmem   = v.wmem;
      e.aluc   = v.aluc;
      e.aluimm = v.aluimm;
      e.shift  = v.shift;
      e.a      = v.exp_ea;
      e.b      = v.exp_eb;
      e.imm    = v.imm;
      e.rs     = v.rs;
      e.rt     = v.rt;
      e.d      = v.d;
    end
    return e;
  endfunction

  task automatic issue(input vec_t v);
    exp_t x;
    @(negedge clk);
    clrn          = v.clrn;
    bus.flush     = v.flush;
    bus.id_wreg   = v.wreg;
    bus.id_m2reg  = v.m2reg;
    bus.id_wmem   = v.wmem;
    bus.id_aluc   = v.aluc;
    bus.id_aluimm = v.aluimm;
    bus.id_shift  = v.shift;
    bus.id_rs     = v.rs;
    bus.id_rt     = v.rt;
    bus.id_d      = v.d;
    bus.id_usert  = v.usert;
    bus.id_qa     = v.qa;
    bus.id_qb     = v.qb;
    bus.id_imm    = v.imm;
    bus.wb_wreg   = v.wb_wreg;
    bus.wb_d      = v.wb_d;
    bus.wdi       = v.wdi;
    x.row   = row_id;
    x.wpcir = v.exp_wpcir;
    x.e     = exp_of(v);
    wp_q.push_back(x);
    ex_q.push_back(x);
    row_id++;
  endtask

  // wpcir monitor: inputs settled, before the capturing edge
  initial begin : mon_wpcir
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (wp_q.size() > 0) begin
        x = wp_q.pop_front();
        n_checks++;
        if (bus.wpcir === x.wpcir) n_pass++;
        else $display("FAIL wpcir row %0d: got %b want %b", x.row, bus.wpcir, x.wpcir);
      end
    end
  end

  // EXE register monitor: just after the capturing edge
  initial begin : mon_exe
    exp_t x;
    exe_t act;
    forever begin
      @(posedge clk);
      #1;
      if (ex_q.size() > 0) begin
        x = ex_q.pop_front();
        act = '{wreg: bus.exe_wreg, m2reg: bus.exe_m2reg, wmem: bus.exe_wmem,
                aluc: bus.ealuc, aluimm: bus.ealuimm, shift: bus.eshift,
                a: bus.ea, b: bus.eb, imm: bus.eimm,
                rs: bus.exe_rs, rt: bus.exe_rt, d: bus.exe_d};
        n_checks++;
        if (act === x.e) n_pass++;
        else $display("FAIL exe row %0d: got %h want %h", x.row, act, x.e);
      end
    end
  end

  initial begin : stim
    vec_t v;
    v = instr(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
    v.clrn = 1'b0;
    clrn          = 1'b0;
    bus.flush     = 1'b0;
    bus.id_wreg   = 1'b0;
    bus.id_m2reg  = 1'b0;
    bus.id_wmem   = 1'b0;
    bus.id_aluc   = '0;
    bus.id_aluimm = 1'b0;
    bus.id_shift  = 1'b0;
    bus.id_rs     = '0;
    bus.id_rt     = '0;
    bus.id_d      = '0;
    bus.id_usert  = 1'b0;
    bus.id_qa     = '0;
    bus.id_qb     = '0;
    bus.id_imm    = '0;
    bus.wb_wreg   = 1'b0;
    bus.wb_d      = '0;
    bus.wdi       = '0;

    // Reset held two cycles with random ID inputs: bubble, wpcir=1
    for (int i = 0; i < 2; i++) begin
      v = instr(1'($urandom), 1'($urandom), RW'($urandom), RW'($urandom),
                RW'($urandom), 1'($urandom), DW'($urandom), DW'($urandom));
      v.clrn    = 1'b0;
      v.wmem    = 1'($urandom);
      v.exp_bub = 1'b1;
      issue(v);
    end
    // Release with a NOP
    v = instr(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
    issue(v);

    // Load r5, then a consumer on rs=5: one stall, then normal capture
    v = instr(1'b1, 1'b1, 5'd1, 5'd2, 5'd5, 1'b0, 32'h0000_0100, 32'h0000_0022);
    issue(v);
    v = instr(1'b1, 1'b0, 5'd5, 5'd6, 5'd8, 1'b1, 32'h0000_00AA, 32'h0000_00BB);
    v.exp_wpcir = 1'b0; v.exp_bub = 1'b1;
    issue(v);
    v.exp_wpcir = 1'b1; v.exp_bub = 1'b0;
    issue(v);

    // Load r7, consumer reads rt=7 with usert=1: stall
    v = instr(1'b1, 1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 32'h0000_0200, 32'h0);
    issue(v);
    v = instr(1'b1, 1'b0, 5'd1, 5'd7, 5'd9, 1'b1, 32'h0000_0031, 32'h0000_0037);
    v.exp_wpcir = 1'b0; v.exp_bub = 1'b1;
    issue(v);
    v.exp_wpcir = 1'b1; v.exp_bub = 1'b0;
    issue(v);

    // Load r7, rt=7 but usert=0: no stall
    v = instr(1'b1, 1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 32'h0000_0204, 32'h0);
    issue(v);
    v = instr(1'b1, 1'b0, 5'd2, 5'd7, 5'd7, 1'b0, 32'h0000_0042, 32'h0000_0047);
    issue(v);

    // Load into r0 followed by rs=rt=0 reader: never stalls
    v = instr(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0000_0300, 32'h0);
    issue(v);
    v = instr(1'b1, 1'b0, 5'd0, 5'd0, 5'd10, 1'b1, 32'h0, 32'h0);
    issue(v);

    // Back-to-back loads into r9, second uses r9 as base, then a consumer
    v = instr(1'b1, 1'b1, 5'd3, 5'd0, 5'd9, 1'b0, 32'h0000_0400, 32'h0);
    issue(v);
    v = instr(1'b1, 1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 32'h0000_0500, 32'h0);
    v.exp_wpcir = 1'b0; v.exp_bub = 1'b1;
    issue(v);
    v.exp_wpcir = 1'b1; v.exp_bub = 1'b0;
    issue(v);
    v = instr(1'b1, 1'b0, 5'd9, 5'd4, 5'd11, 1'b1, 32'h0000_0061, 32'h0000_0064);
    v.exp_wpcir = 1'b0; v.exp_bub = 1'b1;
    issue(v);
    v.exp_wpcir = 1'b1; v.exp_bub = 1'b0;
    issue(v);

    // WB bypass into both operands, then disabled by r0 and by wb_wreg=0
    v = instr(1'b1, 1'b0, 5'd3, 5'd3, 5'd4, 1'b1, 32'h0000_0011, 32'h0000_0011);
    v.wb_wreg = 1'b1; v.wb_d = 5'd3; v.wdi = 32'hDEAD_BEEF;
    v.exp_ea = 32'hDEAD_BEEF; v.exp_eb = 32'hDEAD_BEEF;
    issue(v);
    v.wb_d = 5'd0; v.exp_ea = 32'h0000_0011; v.exp_eb = 32'h0000_0011;
    issue(v);
    v.wb_d = 5'd3; v.wb_wreg = 1'b0;
    issue(v);
    // Store with bypass on rs only
    v = instr(1'b0, 1'b0, 5'd3, 5'd4, 5'd0, 1'b1, 32'h0000_0011, 32'h0000_0044);
    v.wmem = 1'b1; v.shift = 1'b1;
    v.wb_wreg = 1'b1; v.wb_d = 5'd3; v.wdi = 32'hCAFE_0001;
    v.exp_ea = 32'hCAFE_0001;
    issue(v);

    // Load r12, hazard with flush: wpcir=1 and bubble; then normal capture
    v = instr(1'b1, 1'b1, 5'd1, 5'd0, 5'd12, 1'b0, 32'h0000_0600, 32'h0);
    issue(v);
    v = instr(1'b1, 1'b0, 5'd12, 5'd2, 5'd13, 1'b1, 32'h0000_0071, 32'h0000_0072);
    v.flush = 1'b1; v.exp_bub = 1'b1;
    issue(v);
    v = instr(1'b1, 1'b0, 5'd1, 5'd2, 5'd14, 1'b1, 32'h0000_0081, 32'h0000_0082);
    issue(v);
    // Flush without hazard
    v = instr(1'b1, 1'b0, 5'd4, 5'd5, 5'd15, 1'b1, 32'h0000_0091, 32'h0000_0092);
    v.flush = 1'b1; v.exp_bub = 1'b1;
    issue(v);

`ifdef ID_EXE_STALL_CNT_EN
    @(posedge clk);
    #1;
    n_checks++;
    if (stall_cnt === 32'd4) n_pass++;
    else $display("FAIL stall_cnt: got %0d want 4", stall_cnt);
`endif

    // Load r13, then reset asserted while the consumer is presented
    v = instr(1'b1, 1'b1, 5'd1, 5'd0, 5'd13, 1'b0, 32'h0000_0700, 32'h0);
    issue(v);
    v = instr(1'b1, 1'b0, 5'd13, 5'd0, 5'd16, 1'b0, 32'h0000_00A1, 32'h0000_00A2);
    v.clrn = 1'b0; v.exp_bub = 1'b1;
    issue(v);

`ifdef ID_EXE_STALL_CNT_EN
    @(posedge clk);
    #1;
    n_checks++;
    if (stall_cnt === 32'd0) n_pass++;
    else $display("FAIL stall_cnt after reset: got %0d want 0", stall_cnt);
`endif

    // Release: consumer captured normally against the cleared EXE stage
    v.clrn = 1'b1; v.exp_bub = 1'b0;
    issue(v);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && (wp_q.size() > 0 || ex_q.size() > 0); i++) begin
      @(posedge clk);
      #2;
    end
    if (wp_q.size() > 0 || ex_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending want 0", wp_q.size() + ex_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
